// File: rtl/trits_to_trytes_stream.sv
// trits_to_trytes_stream
// Converts one captured Curl hash/state slice of balanced trits into a
// stream of ASCII tryte characters ('9', 'A'..'Z'), one per handshake.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   hash_valid/ready/trits  hash input handshake; trit i at [2i+1:2i]
//                   (00=0, 01=+1, 11=-1, 10=invalid, decoded as 0)
//   flush           synchronous abort of the stream in progress
//   chr_valid/ready/data/last  character output handshake; chr_last marks
//                   character NUM_TRITS/3-1
//   busy            FSM state view: 1 in STREAM, 0 in IDLE
//   err_invalid     sticky flag: captured hash held at least one 2'b10 code
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both 1. While chr_valid=1 and chr_ready=0, chr_data and
// chr_last stay unchanged. hash_valid is only accepted while hash_ready=1.
module trits_to_trytes_stream #(
  parameter int NUM_TRITS = 243
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hash_valid,
  output logic                   hash_ready,
  input  logic [2*NUM_TRITS-1:0] hash_trits,
  input  logic                   flush,
  output logic                   chr_valid,
  input  logic                   chr_ready,
  output logic [7:0]             chr_data,
  output logic                   chr_last,
  output logic                   busy,
  output logic                   err_invalid
);

  localparam int NUM_CHR = NUM_TRITS / 3;
  localparam int IDX_W   = (NUM_CHR > 1) ? $clog2(NUM_CHR) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHR - 1);
  localparam logic ONE_CHR = (NUM_CHR == 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                 state;
  logic [2*NUM_TRITS-1:0] trit_q;
  logic [IDX_W-1:0]       idx;
  logic [2*NUM_TRITS-1:0] trit_shift;
  logic                   any_invalid;

  // Balanced-trit code to signed value; the invalid code counts as 0.
  function automatic logic signed [5:0] trit_val(input logic [1:0] code);
    case (code)
      2'b01:   trit_val = 6'sd1;
      2'b11:   trit_val = -6'sd1;
      default: trit_val = 6'sd0;
    endcase
  endfunction

  // Three trits (t0 in the low bits) to the tryte alphabet character.
  function automatic logic [7:0] tryte_chr(input logic [5:0] t);
    logic signed [5:0] v;
    logic [7:0]        v8;
    v  = trit_val(t[1:0]) + 6'sd3 * trit_val(t[3:2]) + 6'sd9 * trit_val(t[5:4]);
    v8 = {{2{v[5]}}, v};
    if (v == 6'sd0)      tryte_chr = 8'h39;
    else if (v > 6'sd0)  tryte_chr = 8'h40 + v8;
    else                 tryte_chr = 8'h5B + v8;
  endfunction

  // The held hash is shifted one tryte per accepted character, so the
  // current character always comes from the low six bits.
  always_comb begin
    trit_shift  = trit_q >> 6;
    any_invalid = 1'b0;
    for (int i = 0; i < NUM_TRITS; i++) begin
      if (hash_trits[2*i +: 2] == 2'b10) any_invalid = 1'b1;
    end
  end

  assign hash_ready = (state == IDLE);
  assign chr_valid  = (state == STREAM);
  assign busy       = (state == STREAM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      trit_q      <= '0;
      idx         <= '0;
      chr_data    <= 8'h00;
      chr_last    <= 1'b0;
      err_invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // flush has no meaning here and must not block a capture.
          if (hash_valid) begin
            trit_q      <= hash_trits;
            idx         <= '0;
            chr_data    <= tryte_chr(hash_trits[5:0]);
            chr_last    <= ONE_CHR;
            err_invalid <= any_invalid;
            state       <= STREAM;
          end
        end
        STREAM: begin
          // flush wins over a simultaneous character handshake.
          if (flush) begin
            state    <= IDLE;
            idx      <= '0;
            chr_data <= 8'h00;
            chr_last <= 1'b0;
          end else if (chr_ready) begin
            if (idx == LAST_IDX) begin
              state    <= IDLE;
              idx      <= '0;
              chr_data <= 8'h00;
              chr_last <= 1'b0;
            end else begin
              idx      <= idx + 1'b1;
              trit_q   <= trit_shift;
              chr_data <= tryte_chr(trit_shift[5:0]);
              chr_last <= ((idx + 1'b1) == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/trits_to_trytes_stream.md
TRITS_TO_TRYTES_STREAM -- requirements
Module: trits_to_trytes_stream

Interface
REQ-001 Parameter NUM_TRITS, default 243: number of trits in one Curl hash/state slice; SHALL be a positive multiple of 3.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 hash_valid  input  1  producer (Curl squeeze side) offers a hash.
REQ-005 hash_ready  output  1  block can accept a hash.
REQ-006 hash_trits  input  2*NUM_TRITS  trit i at bits [2i+1:2i]; 2'b00=0, 2'b01=+1, 2'b11=-1, 2'b10 invalid.
REQ-007 flush  input  1  synchronous abort of current stream.
REQ-008 chr_valid  output  1  chr_data holds a valid tryte character.
REQ-009 chr_ready  input  1  consumer accepts character.
REQ-010 chr_data  output  8  ASCII tryte character.
REQ-011 chr_last  output  1  marks final character of a hash (index NUM_TRITS/3-1).
REQ-012 busy  output  1  high whenever not in IDLE.
REQ-013 err_invalid  output  1  sticky: an invalid trit code was present in the current hash.

Function
REQ-014 States SHALL be IDLE and STREAM only.
REQ-015 IDLE: hash_ready=1, chr_valid=0; hash_valid&&hash_ready SHALL capture hash_trits into an internal register, clear index to 0, go to STREAM.
REQ-016 Capture SHALL also set err_invalid=1 if any trit equals 2'b10, else clear it; err_invalid holds until the next capture or reset.
REQ-017 STREAM: hash_ready=0; chr_valid SHALL be 1 starting the cycle after capture (latency 1 clock from accepting edge).
REQ-018 Character k SHALL use trits 3k, 3k+1, 3k+2 (t0,t1,t2); value v = t0 + 3*t1 + 9*t2, range -13..+13; invalid code decodes as 0.
REQ-019 Mapping: v=0 -> 0x39 ('9'); v=1..13 -> 0x40+v ('A'..'M'); v=-13..-1 -> 0x5B+v ('N'..'Z').
REQ-020 chr_data/chr_last SHALL be stable while chr_valid=1 and chr_ready=0.
REQ-021 chr_valid&&chr_ready SHALL advance index by 1; at index NUM_TRITS/3-1 chr_last=1 and the handshake SHALL return to IDLE.
REQ-022 After the last handshake, hash_ready SHALL assert in the following cycle; no same-cycle back-to-back capture.
REQ-023 flush in STREAM SHALL return to IDLE on the next edge with chr_valid=0, regardless of a simultaneous chr handshake (flush wins; that character counts as consumed, no further characters emitted).
REQ-024 flush in IDLE SHALL have no effect and SHALL NOT block a simultaneous capture.
REQ-025 Index counter width SHALL be clog2(NUM_TRITS/3), no wrap beyond last index.
REQ-026 hash_trits changes after capture SHALL NOT affect the stream in progress.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, hash_ready=1, chr_valid=0, chr_data=0x00, chr_last=0, busy=0, err_invalid=0, index=0, including mid-stream.
REQ-028 Stream interrupted by reset SHALL NOT resume; next output starts from a fresh capture.

Verification
REQ-029 All-zero hash, chr_ready=1 -> 81 characters 0x39 on consecutive cycles, chr_last only on 81st, hash_ready high the cycle after.
REQ-030 Trytes (+1,0,0),(+1,+1,+1),(-1,-1,-1),(-1,0,0),(0,+1,0) in positions 0..4 -> 'A','M','N','Z','C' (0x41,0x4D,0x4E,0x5A,0x43).
REQ-031 chr_ready toggled 1,0,0,1 pseudo-randomly -> chr_data held during stalls, exactly 81 handshakes, order unchanged.
REQ-032 Trit 5 = 2'b10 -> err_invalid=1 from cycle after capture, character 1 decodes with that trit as 0; next clean hash clears err_invalid.
REQ-033 rst_n low at character 40 -> outputs at reset values asynchronously; new hash after release streams from character 0.
REQ-034 flush together with handshake at character 10 -> chr_valid=0 next cycle, busy=0, hash_ready=1, no character 11.
